timekeeper_gen2: RTL
====================

# timekeeper_gen2

Parametrised successor timekeeper for the digital watch. It holds the 24-hour time of day in seconds, minutes and hours, advanced by a generic-frequency prescaler. Raw push-buttons are synchronised, debounced and edge-detected internally. An edit state machine lets the user clear seconds and step minutes and hours, and a 12/24-hour display view plus a cursor blink signal feed the display driver directly.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency; one second = CLK_HZ cycles (≥ 8)
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples needed to accept a button level (≥ 1)

Ports:
- Clk_50Mhz  in  1  system clock, all logic on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Button1Tk  in  1  raw cursor/mode button, asynchronous, active-high
- Button2Tk  in  1  raw set/increment button, asynchronous, active-high
- Mode12  in  1  1 = HrDisp/Pm in 12-hour form, 0 = 24-hour form
- SecTk  out  6  seconds 0..59
- MinTk  out  6  minutes 0..59
- HrTk  out  5  hours 0..23 (always 24-hour)
- HrDisp  out  5  display hour, see Operation
- Pm  out  1  PM indicator
- Edit  out  2  0 RUN, 1 SEC, 2 MIN, 3 HR
- SecPulse  out  1  one-cycle strobe on each running seconds increment
- Blink  out  1  cursor blink, 2 Hz square wave in edit states

## Operation
- Buttons: 2-flop synchroniser each; debouncer accepts new level after DEBOUNCE_CYCLES consecutive identical synchronised samples (counter restarts on any mismatch); rising edge of accepted level -> one-cycle pulse b1p/b2p. Release produces no pulse.
- Prescaler: counter 0..CLK_HZ-1, width $clog2(CLK_HZ); tick when count == CLK_HZ-1, count -> 0. Runs only in RUN; held at 0 in SEC/MIN/HR.
- Tick: SecTk+1; 59 -> 0 with carry to MinTk; MinTk 59 -> 0 with carry to HrTk; HrTk 23 -> 0. SecPulse = 1 for that cycle.
- Edit FSM: b1p moves RUN->SEC->MIN->HR->RUN. Time frozen in all edit states.
- b2p in SEC: SecTk = 0. In MIN: MinTk+1 mod 60, no carry. In HR: HrTk+1 mod 24. In RUN: ignored.
- b1p and b2p in same cycle: state advance only, b2p discarded.
- HrDisp/Pm combinational from HrTk: Mode12=0 -> HrDisp=HrTk, Pm=0. Mode12=1 -> HrTk 0 -> 12; 1..12 -> same; 13..23 -> HrTk-12; Pm = (HrTk ≥ 12).
- Blink: 1 in RUN. In edit states, toggles every CLK_HZ/4 cycles (integer divide) via own counter, reset to 1 and counter 0 on every Edit change.
- Reset (any time, incl. mid-edit or mid-debounce): SecTk=MinTk=HrTk=0, Edit=0, SecPulse=0, Blink=1, HrDisp reflects HrTk=0, all counters/sync/debounce state 0.

## Timing
- First SecTk increment on the CLK_HZ-th rising edge after Rst_n deasserts; thereafter every CLK_HZ cycles.
- Returning to RUN: prescaler starts from 0, next tick exactly CLK_HZ cycles after the Edit -> 0 edge.
- Button latency: stable high input -> Edit/field update on edge 2 + DEBOUNCE_CYCLES + 1 after first high sample (±1 for input phase).
- SecPulse coincides with the cycle the new SecTk is first visible; never high outside RUN.
- HrDisp/Pm valid same cycle as HrTk (zero latency); Mode12 change reflected same cycle.

## Test plan
Use CLK_HZ=10, DEBOUNCE_CYCLES=4.
- Release reset, run 600 cycles -> SecTk=1 at cycle 10 with single-cycle SecPulse; at cycle 600 MinTk=1, SecTk=0.
- Edit to HR, 23 presses; MIN, 59 presses; back to RUN; run 600 cycles -> 23:59:59 then 00:00:00 on the 600th, single SecPulse.
- Button1 toggling every 2 cycles for 20 cycles then held high 10 cycles -> Edit 0->1 exactly once; release gives no further change.
- Edit=2, 61 Button2 presses over 2000 cycles -> MinTk=1, HrTk and SecTk unchanged, SecPulse never asserts.
- Mode12=1 with HrTk 0/12/13 -> HrDisp 12/12/1, Pm 0/1/1; Mode12=0 with HrTk 13 -> HrDisp 13, Pm 0.
- Edit=3, Blink toggling; assert Rst_n low between edges -> Edit=0, time 00:00:00, Blink=1 immediately, before next clock.

Source files
------------

// File: rtl/timekeeper_gen2_if.sv
// Watch timekeeper signal bundle: raw buttons and view select in, time fields and display view out.
interface timekeeper_gen2_if;
    logic       Button1Tk;
    logic       Button2Tk;
    logic       Mode12;
    logic [5:0] SecTk;
    logic [5:0] MinTk;
    logic [4:0] HrTk;
    logic [4:0] HrDisp;
    logic       Pm;
    logic [1:0] Edit;
    logic       SecPulse;
    logic       Blink;

    modport master (
        output Button1Tk, Button2Tk, Mode12,
        input  SecTk, MinTk, HrTk, HrDisp, Pm, Edit, SecPulse, Blink
    );

    modport slave (
        input  Button1Tk, Button2Tk, Mode12,
        output SecTk, MinTk, HrTk, HrDisp, Pm, Edit, SecPulse, Blink
    );
endinterface

// File: rtl/timekeeper_gen2.sv
// 24-hour time-of-day keeper with debounced edit buttons, 12/24-hour display view and cursor blink.
// The Edit output is the edit FSM state register itself.
module timekeeper_gen2 #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               Clk_50Mhz,
    input  logic               Rst_n,
    timekeeper_gen2_if.slave   tk
);
    localparam int PW   = $clog2(CLK_HZ);
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HALF = CLK_HZ / 4;
    localparam int BW   = $clog2(HALF + 1);

    localparam logic [PW-1:0]  PRE_LAST   = PW'(CLK_HZ - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(HALF - 1);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_SEC = 2'd1,
        ST_MIN = 2'd2,
        ST_HR  = 2'd3
    } edit_e;

    logic [1:0]     raw;
    logic [1:0]     sync1_q;
    logic [1:0]     sync2_q;
    logic [1:0]     db_q;
    logic [DBW-1:0] db_cnt_q [2];
    logic [1:0]     bp_q;

    edit_e          edit_q;
    logic [PW-1:0]  pre_q;
    logic [5:0]     sec_q;
    logic [5:0]     min_q;
    logic [4:0]     hr_q;
    logic           sec_pulse_q;
    logic           blink_q;
    logic [BW-1:0]  blink_cnt_q;

    logic [4:0]     hr_disp_d;
    logic           pm_d;

    assign raw = {tk.Button2Tk, tk.Button1Tk};

    // A level is accepted only after DEBOUNCE_CYCLES samples differing from the current
    // accepted level; any sample equal to it restarts the count. Accepting a 1 emits one pulse.
    always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            bp_q    <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                bp_q[i] <= 1'b0;
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                    bp_q[i]     <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    // Edit FSM plus time registers; a mode-button pulse wins over everything else that cycle.
    always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            edit_q      <= ST_RUN;
            pre_q       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            sec_pulse_q <= 1'b0;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
        end else begin
            sec_pulse_q <= 1'b0;
            if (bp_q[0]) begin
                case (edit_q)
                    ST_RUN:  edit_q <= ST_SEC;
                    ST_SEC:  edit_q <= ST_MIN;
                    ST_MIN:  edit_q <= ST_HR;
                    default: edit_q <= ST_RUN;
                endcase
                pre_q       <= '0;
                blink_q     <= 1'b1;
                blink_cnt_q <= '0;
            end else if (edit_q == ST_RUN) begin
                blink_q     <= 1'b1;
                blink_cnt_q <= '0;
                if (pre_q == PRE_LAST) begin
                    pre_q       <= '0;
                    sec_pulse_q <= 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_q <= '0;
                        if (min_q == 6'd59) begin
                            min_q <= '0;
                            hr_q  <= (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                        end else begin
                            min_q <= min_q + 6'd1;
                        end
                    end else begin
                        sec_q <= sec_q + 6'd1;
                    end
                end else begin
                    pre_q <= pre_q + PW'(1);
                end
            end else begin
                pre_q <= '0;
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_q     <= ~blink_q;
                    blink_cnt_q <= '0;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
                if (bp_q[1]) begin
                    case (edit_q)
                        ST_SEC:  sec_q <= '0;
                        ST_MIN:  min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                        ST_HR:   hr_q  <= (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        hr_disp_d = hr_q;
        pm_d      = 1'b0;
        if (tk.Mode12) begin
            pm_d = (hr_q >= 5'd12);
            if (hr_q == 5'd0) begin
                hr_disp_d = 5'd12;
            end else if (hr_q > 5'd12) begin
                hr_disp_d = hr_q - 5'd12;
            end
        end
    end

    assign tk.SecTk    = sec_q;
    assign tk.MinTk    = min_q;
    assign tk.HrTk     = hr_q;
    assign tk.HrDisp   = hr_disp_d;
    assign tk.Pm       = pm_d;
    assign tk.Edit     = edit_q;
    assign tk.SecPulse = sec_pulse_q;
    assign tk.Blink    = blink_q;
endmodule
